// File: rtl/imem_loader.sv
// rtl/imem_loader.sv - serial byte-stream loader that writes a length-prefixed program into instruction memory
module imem_loader #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int unsigned MAX_WORDS = 1024
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        rx_valid,
  input  logic [7:0]  rx_byte,
  output logic        rx_ready,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_data,
  output logic        cpu_hold,
  output logic        done,
  output logic        error
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEN,
    S_DATA,
    S_WRITE,
    S_DONE,
    S_ERR
  } state_t;

  state_t      state_q;
  logic [1:0]  bcnt_q;
  logic [31:0] idx_q;
  logic [31:0] len_q;
  logic [31:0] word_q;
  logic        rx_ready_q;
  logic        mem_we_q;
  logic [31:0] mem_addr_q;
  logic [31:0] mem_data_q;
  logic        cpu_hold_q;
  logic        done_q;
  logic        error_q;

  // Big-endian assembly: each accepted byte shifts in at the low end.
  logic [31:0] len_d;
  logic [31:0] word_d;
  assign len_d  = {len_q[23:0], rx_byte};
  assign word_d = {word_q[23:0], rx_byte};

  // Loader FSM; outputs are registered alongside the state they belong to,
  // so every output is a pure function of the registered state.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      bcnt_q     <= 2'd0;
      idx_q      <= 32'd0;
      len_q      <= 32'd0;
      word_q     <= 32'd0;
      rx_ready_q <= 1'b0;
      mem_we_q   <= 1'b0;
      mem_addr_q <= BASE_ADDR;
      mem_data_q <= 32'd0;
      cpu_hold_q <= 1'b0;
      done_q     <= 1'b0;
      error_q    <= 1'b0;
    end else begin
      mem_we_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start) begin
            state_q    <= S_LEN;
            bcnt_q     <= 2'd0;
            idx_q      <= 32'd0;
            rx_ready_q <= 1'b1;
            cpu_hold_q <= 1'b1;
          end
        end
        S_LEN: begin
          if (rx_valid) begin
            len_q  <= len_d;
            bcnt_q <= bcnt_q + 2'd1;
            if (bcnt_q == 2'd3) begin
              if (len_d == 32'd0 || len_d > MAX_WORDS) begin
                state_q    <= S_ERR;
                rx_ready_q <= 1'b0;
                error_q    <= 1'b1;
              end else begin
                state_q <= S_DATA;
              end
            end
          end
        end
        S_DATA: begin
          if (rx_valid) begin
            word_q <= word_d;
            bcnt_q <= bcnt_q + 2'd1;
            if (bcnt_q == 2'd3) begin
              state_q    <= S_WRITE;
              rx_ready_q <= 1'b0;
              mem_we_q   <= 1'b1;
              mem_addr_q <= BASE_ADDR + {idx_q[29:0], 2'b00};
              mem_data_q <= word_d;
            end
          end
        end
        S_WRITE: begin
          if (idx_q == len_q - 32'd1) begin
            state_q    <= S_DONE;
            done_q     <= 1'b1;
            cpu_hold_q <= 1'b0;
          end else begin
            state_q    <= S_DATA;
            idx_q      <= idx_q + 32'd1;
            rx_ready_q <= 1'b1;
          end
        end
        S_DONE, S_ERR: begin
          if (start) begin
            state_q    <= S_LEN;
            bcnt_q     <= 2'd0;
            idx_q      <= 32'd0;
            rx_ready_q <= 1'b1;
            cpu_hold_q <= 1'b1;
            done_q     <= 1'b0;
            error_q    <= 1'b0;
          end
        end
        default: begin
          state_q    <= S_IDLE;
          rx_ready_q <= 1'b0;
          cpu_hold_q <= 1'b0;
          done_q     <= 1'b0;
          error_q    <= 1'b0;
        end
      endcase
    end
  end

  assign rx_ready = rx_ready_q;
  assign mem_we   = mem_we_q;
  assign mem_addr = mem_addr_q;
  assign mem_data = mem_data_q;
  assign cpu_hold = cpu_hold_q;
  assign done     = done_q;
  assign error    = error_q;

endmodule

// File: tb/tb_imem_loader.sv
// tb/tb_imem_loader.sv - scoreboard testbench for imem_loader
module tb_imem_loader;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        rx_valid;
  logic [7:0]  rx_byte;
  logic        rx_ready;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_data;
  logic        cpu_hold;
  logic        done;
  logic        error;

  int checks = 0;
  int errors = 0;
  int wr_count = 0;
  bit gap_en = 1'b0;
  logic [63:0] exp_q[$];

  imem_loader #(.BASE_ADDR(32'h0000_0000), .MAX_WORDS(1024)) dut (
    .clk(clk), .reset(reset), .start(start), .rx_valid(rx_valid), .rx_byte(rx_byte),
    .rx_ready(rx_ready), .mem_we(mem_we), .mem_addr(mem_addr), .mem_data(mem_data),
    .cpu_hold(cpu_hold), .done(done), .error(error)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Monitor: every write pulse is matched against the scoreboard head.
  always @(negedge clk) begin
    if (mem_we) begin
      wr_count++;
      chk("rx_ready_in_write", {31'd0, rx_ready}, 32'd0);
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_write actual addr=%h data=%h expected none", mem_addr, mem_data);
      end else begin
        logic [63:0] e;
        e = exp_q.pop_front();
        chk("wr_addr", mem_addr, e[63:32]);
        chk("wr_data", mem_data, e[31:0]);
      end
    end
  end

  task automatic expect_wr(input logic [31:0] a, input logic [31:0] d);
    exp_q.push_back({a, d});
  endtask

  // Present one byte and hold it until accepted; leaves time at posedge+1.
  task automatic send_byte(input logic [7:0] b);
    int n;
    bit ok;
    if (gap_en) begin
      rx_valid = 1'b0;
      @(posedge clk); #1;
    end
    rx_valid = 1'b1;
    rx_byte  = b;
    ok = 1'b0;
    for (n = 0; n < 100 && !ok; n++) begin
      @(negedge clk);
      ok = rx_ready;
    end
    if (!ok) begin
      chk("byte_accept_timeout", 32'd0, 32'd1);
    end
    @(posedge clk); #1;
    rx_valid = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w);
    for (int i = 0; i < 4; i++) send_byte(w[31-8*i -: 8]);
  endtask

  task automatic pulse_start;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_flag(input string name, input bit want_err);
    bit seen;
    seen = 1'b0;
    for (int n = 0; n < 50 && !seen; n++) begin
      @(negedge clk);
      seen = want_err ? error : done;
    end
    chk(name, {31'd0, seen}, 32'd1);
    @(posedge clk); #1;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_rx_ready"}, {31'd0, rx_ready}, 32'd0);
    chk({tag, "_mem_we"},   {31'd0, mem_we},   32'd0);
    chk({tag, "_mem_addr"}, mem_addr,          32'h0);
    chk({tag, "_mem_data"}, mem_data,          32'h0);
    chk({tag, "_cpu_hold"}, {31'd0, cpu_hold}, 32'd0);
    chk({tag, "_done"},     {31'd0, done},     32'd0);
    chk({tag, "_error"},    {31'd0, error},    32'd0);
  endtask

  initial begin
    int base_cnt;
    reset = 1'b1; start = 1'b0; rx_valid = 1'b0; rx_byte = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    chk_reset_outputs("reset");
    reset = 1'b0;

    // Bytes offered while idle must not be consumed.
    rx_valid = 1'b1; rx_byte = 8'hFF;
    repeat (3) @(posedge clk);
    #1;
    rx_valid = 1'b0;

    // Two-word program, back-to-back bytes, with write latency checks.
    base_cnt = wr_count;
    pulse_start();
    chk("len_cpu_hold", {31'd0, cpu_hold}, 32'd1);
    send_word(32'h0000_0002);
    expect_wr(32'h0, 32'h2008_0005);
    send_word(32'h2008_0005);
    chk("latency_we0", {31'd0, mem_we}, 32'd1);
    expect_wr(32'h4, 32'h8C09_0004);
    send_word(32'h8C09_0004);
    chk("latency_we1", {31'd0, mem_we}, 32'd1);
    wait_flag("basic_done", 1'b0);
    chk("basic_cpu_hold", {31'd0, cpu_hold}, 32'd0);
    chk("basic_count", wr_count - base_cnt, 32'd2);

    // Zero-length header is rejected; start from DONE clears done next cycle.
    base_cnt = wr_count;
    pulse_start();
    chk("done_drops", {31'd0, done}, 32'd0);
    send_word(32'h0000_0000);
    wait_flag("zero_len_error", 1'b1);
    chk("err_cpu_hold", {31'd0, cpu_hold}, 32'd1);
    chk("err_rx_ready", {31'd0, rx_ready}, 32'd0);
    chk("err_no_writes", wr_count - base_cnt, 32'd0);

    // Reload from ERR.
    pulse_start();
    chk("error_drops", {31'd0, error}, 32'd0);
    send_word(32'h0000_0001);
    expect_wr(32'h0, 32'hDEAD_BEEF);
    send_word(32'hDEAD_BEEF);
    wait_flag("reload_done", 1'b0);

    // One word over the limit.
    base_cnt = wr_count;
    pulse_start();
    send_word(32'h0000_0401);
    wait_flag("over_max_error", 1'b1);
    chk("over_max_no_writes", wr_count - base_cnt, 32'd0);

    // Exactly MAX_WORDS words.
    base_cnt = wr_count;
    pulse_start();
    send_word(32'h0000_0400);
    for (int i = 0; i < 1024; i++) begin
      expect_wr(32'(i) * 32'd4, 32'hA500_0000 ^ 32'(i));
      send_word(32'hA500_0000 ^ 32'(i));
    end
    wait_flag("max_done", 1'b0);
    chk("max_count", wr_count - base_cnt, 32'd1024);
    chk("max_last_addr", mem_addr, 32'h0000_0FFC);

    // rx_valid toggling on alternate cycles.
    base_cnt = wr_count;
    gap_en = 1'b1;
    pulse_start();
    send_word(32'h0000_0001);
    expect_wr(32'h0, 32'h1234_5678);
    send_word(32'h1234_5678);
    gap_en = 1'b0;
    wait_flag("gap_done", 1'b0);
    chk("gap_count", wr_count - base_cnt, 32'd1);

    // Reset mid-word, with start and rx_valid also high: reset wins.
    base_cnt = wr_count;
    pulse_start();
    send_word(32'h0000_0001);
    send_byte(8'h11);
    send_byte(8'h22);
    reset = 1'b1; start = 1'b1; rx_valid = 1'b1; rx_byte = 8'h33;
    @(posedge clk); #1;
    chk_reset_outputs("midreset");
    reset = 1'b0; start = 1'b0; rx_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("midreset_no_writes", wr_count - base_cnt, 32'd0);
    chk("midreset_idle_ready", {31'd0, rx_ready}, 32'd0);
    pulse_start();
    send_word(32'h0000_0001);
    expect_wr(32'h0, 32'hCAFE_F00D);
    send_word(32'hCAFE_F00D);
    wait_flag("fresh_done", 1'b0);

    // start pulse during DATA must be ignored.
    base_cnt = wr_count;
    pulse_start();
    send_word(32'h0000_0002);
    expect_wr(32'h0, 32'h0102_0304);
    expect_wr(32'h4, 32'h0506_0708);
    send_byte(8'h01);
    send_byte(8'h02);
    pulse_start();
    send_byte(8'h03);
    send_byte(8'h04);
    send_word(32'h0506_0708);
    wait_flag("start_ign_done", 1'b0);
    chk("start_ign_count", wr_count - base_cnt, 32'd2);
    chk("start_ign_last_addr", mem_addr, 32'h4);

    repeat (3) @(posedge clk);
    chk("scoreboard_empty", exp_q.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/imem_loader.md
IMEM_LOADER -- requirements
Module: imem_loader

Interface
REQ-001 Parameter BASE_ADDR, default 32'h0000_0000, byte address of first instruction word written.
REQ-002 Parameter MAX_WORDS, default 1024, largest legal program length in 32-bit words.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 start  input  1  single-cycle request to begin a program load.
REQ-006 rx_valid  input  1  rx_byte holds a valid byte.
REQ-007 rx_byte  input  8  serial program stream byte.
REQ-008 rx_ready  output  1  loader can accept a byte; a byte transfers when rx_valid && rx_ready at a rising edge.
REQ-009 mem_we  output  1  instruction-memory write enable, one cycle per word.
REQ-010 mem_addr  output  32  instruction-memory byte address.
REQ-011 mem_data  output  32  instruction word to write.
REQ-012 cpu_hold  output  1  holds the CPU PC/fetch path off while loading or in error.
REQ-013 done  output  1  level, program loaded successfully.
REQ-014 error  output  1  level, length header rejected.

Function
REQ-015 FSM states SHALL be IDLE, LEN, DATA, WRITE, DONE, ERR; all outputs are Moore, decoded from registered state.
REQ-016 IDLE: rx_ready=0, cpu_hold=0; start=1 -> LEN, byte counter and word index cleared.
REQ-017 LEN: rx_ready=1, cpu_hold=1; four accepted bytes form length L, big-endian (first byte = bits 31:24).
REQ-018 After fourth LEN byte: L==0 or L>MAX_WORDS -> ERR; else -> DATA.
REQ-019 DATA: rx_ready=1, cpu_hold=1; four accepted bytes form word W, big-endian; after fourth byte -> WRITE.
REQ-020 WRITE: rx_ready=0, mem_we=1 for exactly one cycle, mem_addr=BASE_ADDR+4*idx, mem_data=W.
REQ-021 Latency: mem_we high in the cycle immediately after the edge accepting a word's fourth byte.
REQ-022 WRITE exit: idx==L-1 -> DONE; else idx increments by 1 -> DATA.
REQ-023 mem_addr arithmetic SHALL be 32-bit modulo 2^32; wrap is not flagged.
REQ-024 mem_we=0 in every state except WRITE; mem_addr/mem_data hold last values outside WRITE.
REQ-025 DONE: done=1, cpu_hold=0, rx_ready=0; start -> LEN (done drops next cycle).
REQ-026 ERR: error=1, cpu_hold=1, rx_ready=0; start -> LEN (error drops next cycle).
REQ-027 start in LEN, DATA or WRITE SHALL be ignored; load continues.
REQ-028 rx_valid gaps of any length SHALL stall collection without losing partial bytes.
REQ-029 Bytes presented while rx_ready=0 SHALL not be consumed.

Reset
REQ-030 reset=1 at a rising edge SHALL force IDLE, byte counter=0, idx=0, L=0, W=0, mem_we=0, mem_addr=BASE_ADDR, mem_data=0, rx_ready=0, cpu_hold=0, done=0, error=0.
REQ-031 reset mid-load SHALL abandon the load with no further mem_we; memory already written is not restored.
REQ-032 reset has priority over start and rx_valid in the same cycle.

Verification
REQ-033 start, stream 00 00 00 02, 20 08 00 05, 8C 09 00 04 back-to-back -> mem_we at addr 0x0 data 0x20080005, then addr 0x4 data 0x8C090004; done=1, cpu_hold=0.
REQ-034 start, header 00 00 00 00 -> ERR: error=1, cpu_hold=1, zero mem_we pulses; start again reloads normally.
REQ-035 header 00 00 04 01 with MAX_WORDS=1024 -> error=1; header 00 00 04 00 -> accepted, 1024 writes, last addr BASE_ADDR+0xFFC.
REQ-036 rx_valid toggling 1/0 every cycle during a 1-word load -> single correct write, no byte lost or duplicated, rx_ready=0 during WRITE.
REQ-037 reset asserted after 2 data bytes of word 0 -> next cycle all outputs at reset values, no mem_we; fresh load succeeds.
REQ-038 start pulsed during DATA -> ignored; word count and addresses unchanged versus a run without the pulse.
